// File: rtl/msg_stream_tx.sv
// msg_stream_tx: streams a fixed ASCII message over valid/ready with repeat, loop, inter-pass gap and abort
module msg_stream_tx #(
  parameter int                   MSG_LEN = 11,
  parameter logic [8*MSG_LEN-1:0] MSG     = "Hello World",
  parameter int                   CNT_W   = 8,
  parameter int                   GAP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode_loop,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_idx
);
  localparam int IW = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1;
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  localparam logic [IW-1:0] LAST   = IW'(MSG_LEN - 1);
  localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] pass_q, pass_d, rem_q, rem_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             loop_q, loop_d;
  logic [7:0]       chars [MSG_LEN];
  for (genvar i = 0; i < MSG_LEN; i++) begin : g_ch
    assign chars[i] = MSG[8*(MSG_LEN-1-i) +: 8];
  end
  assign out_valid = state_q == SEND;
  assign out_data  = out_valid ? chars[idx_q] : 8'd0;
  assign out_last  = out_valid && idx_q == LAST;
  assign busy      = state_q == SEND || state_q == GAP;
  assign done      = state_q == DONE;
  assign pass_idx  = pass_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    loop_d  = loop_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = SEND;
        idx_d   = '0;
        pass_d  = '0;
        rem_d   = repeat_cnt == '0 ? CNT_W'(1) : repeat_cnt;
        loop_d  = mode_loop;
      end
      SEND: if (out_ready) begin
        idx_d = out_last ? '0 : idx_q + IW'(1);
        if (out_last) begin
          pass_d  = pass_q + CNT_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          gap_d   = GAP_LD;
          state_d = !(loop_q || rem_q > CNT_W'(1)) ? DONE : GAP_CYC > 0 ? GAP : SEND;
        end
      end
      GAP: begin
        gap_d   = gap_q - GW'(1);
        state_d = gap_q == '0 ? SEND : GAP;
      end
      DONE: state_d = IDLE;
    endcase
    // abort wins over start and over a beat being accepted this cycle
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      pass_d  = pass_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pass_q  <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      loop_q  <= loop_d;
    end
  end
endmodule

// File: tb/tb_msg_stream_tx.sv
// tb_msg_stream_tx: randomized handshake bench checking the byte stream against the message text
module tb_msg_stream_tx;
  localparam int L   = 11;
  localparam int GAP = 4;
  logic       clk = 0, rst = 1, start = 0, abort = 0, mode_loop = 0, out_ready = 0;
  logic [7:0] repeat_cnt = 0;
  logic       out_valid, out_last, busy, done;
  logic [7:0] out_data, pass_idx;
  string      msg = "Hello World";
  int         errs = 0, n_chk = 0;
  msg_stream_tx dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_loop(mode_loop),
    .repeat_cnt(repeat_cnt), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .pass_idx(pass_idx)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic idle_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask
  // n passes (0 counts as 1), lp loop, pct ready %, abort/mid-start/reset triggered at k accepted beats
  task automatic run(input int n, input bit lp, input int pct, input int abort_at, input int mid_at, input int rst_at);
    int k = 0, gap_n = 0, total;
    bit gap_open = 0, stall = 0, fin = 0, ended = 0;
    int hold = 0;
    total = (n == 0 ? 1 : n) * L;
    @(negedge clk);
    start = 1; repeat_cnt = 8'(n); mode_loop = lp; out_ready = 0;
    @(negedge clk);
    start = 0; mode_loop = 0; repeat_cnt = 8'd5;
    check("first_valid", out_valid, 1);
    for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
      if (fin) begin
        check("done_pulse", done, 1);
        check("done_valid", out_valid, 0);
        check("done_busy", busy, 0);
        check("done_pass", pass_idx, n == 0 ? 1 : n);
        out_ready = 0;
        @(negedge clk);
        check("done_once", done, 0);
        check("idle_valid", out_valid, 0);
        ended = 1;
      end else begin
        check("no_done", done, 0);
        check("busy", busy, 1);
        check("pass", pass_idx, (k / L) % 256);
        if (out_valid) begin
          if (gap_open) check("gap_len", gap_n, GAP);
          gap_open = 0;
          if (stall) check("stable", {out_data, out_last}, hold);
          check("data", out_data, msg[k % L]);
          check("last", out_last, (k % L) == L - 1);
        end else if (gap_open) gap_n++;
        else check("bubble", out_valid, 1);
        start = (mid_at >= 0 && k == mid_at);
        if (rst_at >= 0 && k == rst_at && out_valid) begin
          out_ready = 0; rst = 1;
          @(negedge clk);
          rst = 0;
          idle_zero("rst_mid");
          check("rst_pass", pass_idx, 0);
          ended = 1;
        end else if (abort_at >= 0 && k == abort_at) begin
          out_ready = 1; abort = 1;
          @(negedge clk);
          abort = 0; out_ready = 0;
          idle_zero("abort");
          check("abort_pass", pass_idx, (k / L) % 256);
          @(negedge clk);
          check("abort_nodone", done, 0);
          check("abort_hold", pass_idx, (k / L) % 256);
          ended = 1;
        end else begin
          out_ready = $urandom_range(99) < pct;
          stall = out_valid && !out_ready;
          hold = {out_data, out_last};
          if (out_valid && out_ready) begin
            k++;
            if (k % L == 0) begin
              if (!lp && k == total) fin = 1;
              else begin gap_open = GAP > 0; gap_n = 0; end
            end
          end
          @(negedge clk);
        end
      end
    end
    start = 0;
    if (!ended) check("timeout", 0, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    idle_zero("reset");
    check("reset_pass", pass_idx, 0);
    rst = 0;
    run(1, 0, 100, -1, -1, -1);
    run(3, 0, 100, -1, -1, -1);
    run(1, 0, 50, -1, -1, -1);
    run(2, 0, 50, -1, -1, -1);
    run(0, 1, 100, 25, -1, -1);
    run(0, 1, 60, 30, -1, -1);
    run(0, 0, 60, -1, 5, -1);
    @(negedge clk);
    start = 1; abort = 1; repeat_cnt = 8'd2;
    @(negedge clk);
    start = 0; abort = 0;
    idle_zero("start_abort");
    @(negedge clk);
    check("start_abort_stay", busy, 0);
    run(2, 0, 50, -1, -1, 4);
    run(1, 0, 100, -1, -1, -1);
    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule
